ram_cmd_arbiter: RTL and testbench
==================================

RAM_CMD_ARBITER -- requirements
Module: ram_cmd_arbiter

Interface
REQ-001 Parameter: RD_TIMEOUT, default 15, is the maximum number of RWAIT cycles allowed before a read is failed.
REQ-002 clk  in  1  clock; all logic is rising-edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  2  per-requester transaction request, bit i = requester i.
REQ-005 req_ready  out  2  per-requester accept; a transaction transfers on a cycle where req_valid[i] and req_ready[i] are both high.
REQ-006 req_wr  in  2  per-requester op select: 1 = write, 0 = read.
REQ-007 req_addr  in  16  packed addresses, {req1[7:0], req0[7:0]}.
REQ-008 req_wdata  in  16  packed write data, {req1[7:0], req0[7:0]}.
REQ-009 rsp_valid  out  2  one-cycle completion pulse for requester i.
REQ-010 rsp_err  out  1  read timeout flag, qualified by rsp_valid.
REQ-011 rsp_rdata  out  8  read data, qualified by rsp_valid.
REQ-012 ram_din  out  10  RAM command word: {opcode[1:0], payload[7:0]}.
REQ-013 ram_rx_valid  out  1  RAM command strobe.
REQ-014 ram_tx_valid  in  1  RAM read-data strobe.
REQ-015 ram_dout  in  8  RAM read data.

Function
REQ-016 FSM states: IDLE, ADDR, DATA, RCMD, RWAIT.
REQ-017 IDLE: if any req_valid is high, the grant winner's req_ready bit shall be high for that one cycle; the block latches wr/addr/wdata and the grant id, then moves to ADDR. req_ready shall be 0 in every other state.
REQ-018 Arbitration: round-robin over two requesters. A sole requester always wins. On a tie, the winner is the requester other than last_grant; last_grant updates on every grant.
REQ-019 ADDR: ram_rx_valid=1, ram_din={wr?2'b00:2'b10, addr}. Next state is DATA for a write, RCMD for a read.
REQ-020 DATA: ram_rx_valid=1, ram_din={2'b01, wdata}. Next state is IDLE; rsp_valid[g] pulses on the following cycle with rsp_err=0.
REQ-021 RCMD: ram_rx_valid=1, ram_din={2'b11, 8'h00}. Next state is RWAIT.
REQ-022 RWAIT: ram_rx_valid=0. On ram_tx_valid, register ram_dout into rsp_rdata, pulse rsp_valid[g] on the next cycle with rsp_err=0, and go to IDLE.
REQ-023 Timeout: after RD_TIMEOUT consecutive RWAIT cycles without ram_tx_valid, pulse rsp_valid[g] on the next cycle with rsp_err=1 and rsp_rdata=8'h00, then go to IDLE. If tx_valid arrives on the last allowed cycle, the data result wins.
REQ-024 Latency (accept at cycle T): write completes with rsp_valid at T+3; read completes with rsp_valid at T+4 when the RAM answers at T+3. Next accept is possible at T+3 (write) or T+4 (read).
REQ-025 ram_tx_valid outside RWAIT shall be ignored, with no state or output effect.
REQ-026 Outside ADDR/DATA/RCMD: ram_rx_valid=0 and ram_din holds its last value.
REQ-027 RAM outputs shall be decoded from registered state only, with no combinational path from any req_* input.
REQ-028 rsp_valid shall be one-hot or zero and shall never stay high for more than one cycle.

Reset
REQ-029 While rst_n=0 at a clk edge, the block shall force: state=IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_din=0, ram_rx_valid=0, last_grant=1 (requester 0 wins the first tie), timeout counter=0.
REQ-030 A reset during any non-IDLE state shall drop the in-flight transaction silently, with no rsp_valid for it.

Structure
REQ-031 Shared package ram_arb_pkg shall hold the opcode constants (OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11) and the FSM state enum.
REQ-032 Arbitration shall live in one sub-module, ram_arb_rr2, with inputs req[1:0] and advance, and outputs grant_onehot and grant_id, holding last_grant internally.

Verification
REQ-033 Write: req0 wr=1, addr 0x3C, wdata 0xA5, accepted at T -> ram_din 0x03C at T+1 and 0x1A5 at T+2 (rx_valid high both cycles), rsp_valid=2'b01 at T+3, rsp_err=0.
REQ-034 Read back: req1 wr=0, addr 0x3C after REQ-033, accepted at T -> ram_din 0x23C at T+1 and 0x300 at T+2, rsp_valid=2'b10 at T+4, rsp_rdata=0xA5.
REQ-035 Contention: both requesters hold req_valid continuously after reset -> grant order is 0,1,0,1, with no back-to-back grants to the same requester.
REQ-036 Timeout: read accepted at T with a RAM model that never asserts tx_valid, RD_TIMEOUT=15 -> rsp_valid at T+18, rsp_err=1, rsp_rdata=0x00; the block then returns to IDLE.
REQ-037 Reset mid-read: rst_n=0 for one cycle during RWAIT -> ram_rx_valid=0 and rsp_valid=0 from the next edge, no response for the dropped read, and the next write (addr 0x01, data 0x5A) completes per REQ-024.
REQ-038 Stray strobe: ram_tx_valid pulsed in IDLE, ADDR and DATA -> no rsp_valid and no change to rsp_rdata.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg -- shared definitions for the RAM command arbiter.
//   Opcodes carried in ram_din[9:8], the controller FSM state encoding,
//   and a helper that turns a requester id into a one-hot response vector.
package ram_arb_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_RCMD  = 3'd3,
        ST_RWAIT = 3'd4
    } state_t;

    function automatic logic [1:0] id_onehot(input logic id);
        return {id, ~id};
    endfunction

endpackage

// File: rtl/ram_arb_rr2.sv
// ram_arb_rr2 -- two-requester round-robin arbiter.
//   clk, rst_n      : clock, synchronous active-low reset
//   req[1:0]        : requests
//   advance         : a grant is being consumed this cycle
//   grant_onehot    : one-hot winner (zero when no request)
//   grant_id        : winner index
// last_grant resets to 1 so requester 0 wins the first tie.
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant_onehot,
    output logic       grant_id
);

    logic r_last_grant;
    logic w_id;

    always_comb begin
        w_id = 1'b0;
        case (req)
            2'b10:   w_id = 1'b1;
            2'b11:   w_id = ~r_last_grant;
            default: w_id = 1'b0;
        endcase
    end

    assign grant_id     = w_id;
    assign grant_onehot = (req == 2'b00) ? 2'b00 : id_onehot(w_id);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (advance && (req != 2'b00)) begin
            r_last_grant <= w_id;
        end
    end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter -- serialises byte read/write transactions from two
// requesters onto a single RAM command port.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : per-requester handshake (transfer when both high)
//   req_wr, req_addr, req_wdata : per-requester op, packed {req1, req0}
//   rsp_valid[1:0]      : one-cycle completion pulse, one-hot
//   rsp_err, rsp_rdata  : read timeout flag / read data, qualified by rsp_valid
//   ram_din, ram_rx_valid : command word {opcode, payload} and strobe
//   ram_tx_valid, ram_dout : RAM read-data strobe and data
//   dbg_state           : current FSM state (state_t encoding)
// Handshake: req_ready is only ever high in IDLE, for the arbitration winner,
// and the transaction is captured on the edge where req_valid & req_ready.
// RAM-side outputs are registers loaded with the value for the next state, so
// they never depend combinationally on req_* inputs.
module ram_cmd_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RD_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic        rsp_err,
    output logic [7:0]  rsp_rdata,
    output logic [9:0]  ram_din,
    output logic        ram_rx_valid,
    input  logic        ram_tx_valid,
    input  logic [7:0]  ram_dout,
    output logic [2:0]  dbg_state
);

    localparam int CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    state_t           r_state;
    logic             r_wr;
    logic [7:0]       r_wdata;
    logic             r_gid;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_rsp_valid;
    logic             r_rsp_err;
    logic [7:0]       r_rsp_rdata;
    logic [9:0]       r_ram_din;
    logic             r_ram_rx_valid;

    logic [1:0] w_grant_onehot;
    logic       w_grant_id;
    logic       w_accept;
    logic       w_sel_wr;
    logic [7:0] w_sel_addr;
    logic [7:0] w_sel_wdata;

    // Gated by rst_n so nothing is offered while reset is asserted.
    assign w_accept = (r_state == ST_IDLE) && rst_n && (req_valid != 2'b00);

    ram_arb_rr2 u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_valid),
        .advance      (w_accept),
        .grant_onehot (w_grant_onehot),
        .grant_id     (w_grant_id)
    );

    assign w_sel_wr    = w_grant_id ? req_wr[1]        : req_wr[0];
    assign w_sel_addr  = w_grant_id ? req_addr[15:8]   : req_addr[7:0];
    assign w_sel_wdata = w_grant_id ? req_wdata[15:8]  : req_wdata[7:0];

    assign req_ready    = w_accept ? w_grant_onehot : 2'b00;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_err      = r_rsp_err;
    assign rsp_rdata    = r_rsp_rdata;
    assign ram_din      = r_ram_din;
    assign ram_rx_valid = r_ram_rx_valid;
    assign dbg_state    = r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_wr           <= 1'b0;
            r_wdata        <= 8'h00;
            r_gid          <= 1'b0;
            r_cnt          <= '0;
            r_rsp_valid    <= 2'b00;
            r_rsp_err      <= 1'b0;
            r_rsp_rdata    <= 8'h00;
            r_ram_din      <= 10'h000;
            r_ram_rx_valid <= 1'b0;
        end else begin
            r_rsp_valid    <= 2'b00;
            r_ram_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_wr           <= w_sel_wr;
                        r_wdata        <= w_sel_wdata;
                        r_gid          <= w_grant_id;
                        r_ram_din      <= {(w_sel_wr ? OP_WR_ADDR : OP_RD_ADDR), w_sel_addr};
                        r_ram_rx_valid <= 1'b1;
                        r_state        <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_ram_rx_valid <= 1'b1;
                    if (r_wr) begin
                        r_ram_din <= {OP_WR_DATA, r_wdata};
                        r_state   <= ST_DATA;
                    end else begin
                        r_ram_din <= {OP_RD_DATA, 8'h00};
                        r_state   <= ST_RCMD;
                    end
                end
                ST_DATA: begin
                    r_rsp_valid <= id_onehot(r_gid);
                    r_rsp_err   <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                ST_RCMD: begin
                    r_cnt   <= '0;
                    r_state <= ST_RWAIT;
                end
                ST_RWAIT: begin
                    // Data is checked first so a strobe on the final
                    // allowed cycle still completes as a good read.
                    if (ram_tx_valid) begin
                        r_rsp_valid <= id_onehot(r_gid);
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= ram_dout;
                        r_state     <= ST_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rsp_valid <= id_onehot(r_gid);
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 8'h00;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// tb_ram_cmd_arbiter -- directed bench for ram_cmd_arbiter.
// Inputs change and outputs are sampled on the falling clock edge; "cycle T"
// is the clock period in which a request is accepted.
module tb_ram_cmd_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [7:0]  rsp_rdata;
    logic [9:0]  ram_din;
    logic        ram_rx_valid;
    logic        ram_tx_valid;
    logic [7:0]  ram_dout;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    ram_cmd_arbiter #(.RD_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_tx_valid (ram_tx_valid),
        .ram_dout     (ram_dout),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] grants [4];
        int         ng;
        logic [1:0] seen;

        rst_n        = 1'b0;
        req_valid    = 2'b11;
        req_wr       = 2'b00;
        req_addr     = 16'h0000;
        req_wdata    = 16'h0000;
        ram_tx_valid = 1'b0;
        ram_dout     = 8'h00;

        // Reset state (req_valid high to show ready is held low).
        tick(); tick();
        chk("rst_req_ready", 16'(req_ready), 16'h0);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rst_rsp_err",   16'(rsp_err), 16'h0);
        chk("rst_rsp_rdata", 16'(rsp_rdata), 16'h00);
        chk("rst_ram_din",   16'(ram_din), 16'h000);
        chk("rst_rx_valid",  16'(ram_rx_valid), 16'h0);
        chk("rst_state",     16'(dbg_state), 16'd0);

        // Contention: both hold valid with writes; expect grants 0,1,0,1.
        rst_n     = 1'b1;
        req_wr    = 2'b11;
        req_addr  = 16'h2211;
        req_wdata = 16'hB2B1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #1;
            if ((req_ready & req_valid) != 2'b00) begin
                grants[ng] = req_ready;
                ng++;
            end
            tick();
        end
        req_valid = 2'b00;
        chk("cont_grant_cnt", 16'(ng), 16'd4);
        chk("cont_grant0", 16'(grants[0]), 16'b01);
        chk("cont_grant1", 16'(grants[1]), 16'b10);
        chk("cont_grant2", 16'(grants[2]), 16'b01);
        chk("cont_grant3", 16'(grants[3]), 16'b10);
        tick(); tick(); tick();
        chk("cont_idle", 16'(dbg_state), 16'd0);

        // Stray strobe in IDLE.
        ram_tx_valid = 1'b1;
        ram_dout     = 8'hEE;
        tick();
        chk("stray_idle_rsp", 16'(rsp_valid), 16'h0);
        chk("stray_idle_rdata", 16'(rsp_rdata), 16'h00);

        // Write req0 addr 3C data A5, strobe kept high through IDLE/ADDR/DATA.
        req_valid = 2'b01;
        req_wr    = 2'b01;
        req_addr  = 16'h003C;
        req_wdata = 16'h00A5;
        #1;
        chk("wr_ready", 16'(req_ready), 16'b01);
        tick();                                   // T+1
        chk("wr_ready_busy", 16'(req_ready), 16'b00);
        req_valid = 2'b00;
        chk("wr_din_addr", 16'(ram_din), 16'h03C);
        chk("wr_rx_addr",  16'(ram_rx_valid), 16'h1);
        tick();                                   // T+2
        chk("wr_din_data", 16'(ram_din), 16'h1A5);
        chk("wr_rx_data",  16'(ram_rx_valid), 16'h1);
        chk("wr_rsp_early", 16'(rsp_valid), 16'h0);
        ram_tx_valid = 1'b0;
        tick();                                   // T+3
        chk("wr_rsp_valid", 16'(rsp_valid), 16'b01);
        chk("wr_rsp_err",   16'(rsp_err), 16'h0);
        chk("wr_rdata_kept", 16'(rsp_rdata), 16'h00);
        chk("wr_rx_off",    16'(ram_rx_valid), 16'h0);
        chk("wr_din_hold",  16'(ram_din), 16'h1A5);
        tick();                                   // T+4
        chk("wr_rsp_pulse", 16'(rsp_valid), 16'h0);

        // Read back via req1, RAM answers at T+3.
        req_valid = 2'b10;
        req_wr    = 2'b00;
        req_addr  = 16'h3C00;
        #1;
        chk("rd_ready", 16'(req_ready), 16'b10);
        tick();                                   // T+1
        req_valid = 2'b00;
        chk("rd_din_addr", 16'(ram_din), 16'h23C);
        chk("rd_rx_addr",  16'(ram_rx_valid), 16'h1);
        tick();                                   // T+2
        chk("rd_din_cmd", 16'(ram_din), 16'h300);
        chk("rd_rx_cmd",  16'(ram_rx_valid), 16'h1);
        tick();                                   // T+3
        chk("rd_rx_wait", 16'(ram_rx_valid), 16'h0);
        chk("rd_state_wait", 16'(dbg_state), 16'd4);
        ram_tx_valid = 1'b1;
        ram_dout     = 8'hA5;
        tick();                                   // T+4
        ram_tx_valid = 1'b0;
        chk("rd_rsp_valid", 16'(rsp_valid), 16'b10);
        chk("rd_rsp_err",   16'(rsp_err), 16'h0);
        chk("rd_rsp_rdata", 16'(rsp_rdata), 16'hA5);
        tick();
        chk("rd_rsp_pulse", 16'(rsp_valid), 16'h0);

        // Timeout: req0 read, RAM silent -> response at T+18 with error.
        req_valid = 2'b01;
        req_addr  = 16'h0055;
        tick();                                   // T+1
        req_valid = 2'b00;
        seen = 2'b00;
        for (int k = 1; k < 18; k++) begin
            seen |= rsp_valid;
            tick();
        end                                       // now T+18
        chk("to_no_early_rsp", 16'(seen), 16'h0);
        chk("to_rsp_valid", 16'(rsp_valid), 16'b01);
        chk("to_rsp_err",   16'(rsp_err), 16'h1);
        chk("to_rsp_rdata", 16'(rsp_rdata), 16'h00);
        chk("to_state_idle", 16'(dbg_state), 16'd0);
        tick();
        chk("to_rsp_pulse", 16'(rsp_valid), 16'h0);

        // Data strobe on the last allowed RWAIT cycle wins over timeout.
        req_valid = 2'b01;
        req_addr  = 16'h0010;
        tick();                                   // T+1
        req_valid = 2'b00;
        for (int k = 1; k < 17; k++) tick();      // T+17
        ram_tx_valid = 1'b1;
        ram_dout     = 8'hC3;
        tick();                                   // T+18
        ram_tx_valid = 1'b0;
        chk("last_rsp_valid", 16'(rsp_valid), 16'b01);
        chk("last_rsp_err",   16'(rsp_err), 16'h0);
        chk("last_rsp_rdata", 16'(rsp_rdata), 16'hC3);
        tick();

        // Reset during RWAIT drops the read.
        req_valid = 2'b10;
        req_addr  = 16'h7700;
        tick();                                   // T+1
        req_valid = 2'b00;
        tick(); tick(); tick();                   // T+4, in RWAIT
        chk("mr_in_wait", 16'(dbg_state), 16'd4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_rx_valid", 16'(ram_rx_valid), 16'h0);
        chk("mr_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("mr_state", 16'(dbg_state), 16'd0);
        seen = 2'b00;
        for (int k = 0; k < 20; k++) begin
            seen |= rsp_valid;
            tick();
        end
        chk("mr_no_rsp", 16'(seen), 16'h0);

        // Write after reset: addr 01, data 5A.
        req_valid = 2'b01;
        req_wr    = 2'b01;
        req_addr  = 16'h0001;
        req_wdata = 16'h005A;
        #1;
        chk("pw_ready", 16'(req_ready), 16'b01);
        tick();
        req_valid = 2'b00;
        chk("pw_din_addr", 16'(ram_din), 16'h001);
        tick();
        chk("pw_din_data", 16'(ram_din), 16'h15A);
        tick();
        chk("pw_rsp_valid", 16'(rsp_valid), 16'b01);
        chk("pw_rsp_err",   16'(rsp_err), 16'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
